// File: rtl/semaphore_arbiter_bank.sv
// semaphore_arbiter_bank: NUM_SEM counting semaphores shared by NUM_CORES cores.
// Each core raises REQ with an op (READ/ACQUIRE/RELEASE/INIT). One request is
// granted per cycle in round-robin order. The op executes atomically on the
// grant edge and is acknowledged one cycle later with OK and the post-op count.
// Optional macro SEM_OWNER_CHECK_EN: track an owner per semaphore and refuse
// RELEASE from any core other than the owner.
module semaphore_arbiter_bank #(
  parameter int NUM_SEM   = 4,
  parameter int NUM_CORES = 2,
  parameter int CNT_W     = 4,
  parameter int RESET_CNT = 1,
  parameter int SEM_AW    = (NUM_SEM   > 1) ? $clog2(NUM_SEM)   : 1,
  parameter int CORE_AW   = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                        CLK,
  input  logic                        RESET_n,
  input  logic [NUM_CORES-1:0]        CORE_REQ,
  input  logic [2*NUM_CORES-1:0]      CORE_OP,
  input  logic [SEM_AW*NUM_CORES-1:0] CORE_SEM,
  input  logic [CNT_W*NUM_CORES-1:0]  CORE_DATA,
  output logic [NUM_CORES-1:0]        CORE_ACK,
  output logic [NUM_CORES-1:0]        CORE_OK,
  output logic [CNT_W*NUM_CORES-1:0]  CORE_RDATA,
  output logic [NUM_SEM-1:0]          SEM_NONZERO
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_RST = CNT_W'(RESET_CNT);

  typedef enum logic [1:0] {
    OP_READ    = 2'b00,
    OP_ACQUIRE = 2'b01,
    OP_RELEASE = 2'b10,
    OP_INIT    = 2'b11
  } op_e;

  logic [CNT_W-1:0]           cnt_q [NUM_SEM];
  logic [CNT_W-1:0]           cnt_d [NUM_SEM];
  logic [CORE_AW-1:0]         rr_q, rr_d;
  logic [NUM_CORES-1:0]       ack_q, ack_d;
  logic [NUM_CORES-1:0]       ok_q, ok_d;
  logic [CNT_W*NUM_CORES-1:0] rdata_q, rdata_d;
  logic [NUM_SEM-1:0]         nz_q, nz_d;
`ifdef SEM_OWNER_CHECK_EN
  logic [CORE_AW-1:0]         owner_q [NUM_SEM];
  logic [CORE_AW-1:0]         owner_d [NUM_SEM];
`endif

  logic [NUM_CORES-1:0] elig;
  logic                 gnt_vld;
  logic [CORE_AW-1:0]   gnt_idx;
  op_e                  op_g;
  logic [SEM_AW-1:0]    sem_g, sem_ix;
  logic [CNT_W-1:0]     data_g, cur_g, res_cnt;
  logic                 sem_vld, res_ok;

  // A core being acked this cycle is masked so a held REQ re-arbitrates next cycle
  assign elig = CORE_REQ & ~ack_q;

  // Round-robin search upward from rr_q with wrap-around
  always_comb begin
    int cand;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = 0;
    for (int k = 0; k < NUM_CORES; k++) begin
      cand = (int'(rr_q) + k) % NUM_CORES;
      if (!gnt_vld && elig[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = CORE_AW'(cand);
      end
    end
  end

  assign op_g    = op_e'(CORE_OP[2*int'(gnt_idx) +: 2]);
  assign sem_g   = CORE_SEM[SEM_AW*int'(gnt_idx) +: SEM_AW];
  assign data_g  = CORE_DATA[CNT_W*int'(gnt_idx) +: CNT_W];
  assign sem_vld = (int'(sem_g) < NUM_SEM);
  assign sem_ix  = sem_vld ? sem_g : '0;
  assign cur_g   = cnt_q[sem_ix];

  // Execute the granted op and stage the per-core response
  always_comb begin
    cnt_d   = cnt_q;
    ack_d   = '0;
    ok_d    = ok_q;
    rdata_d = rdata_q;
    rr_d    = rr_q;
    res_ok  = 1'b0;
    res_cnt = '0;
`ifdef SEM_OWNER_CHECK_EN
    owner_d = owner_q;
`endif
    if (gnt_vld) begin
      ack_d[gnt_idx] = 1'b1;
      rr_d = (int'(gnt_idx) == NUM_CORES - 1) ? '0 : gnt_idx + 1'b1;
      if (sem_vld) begin
        res_cnt = cur_g;
        unique case (op_g)
          OP_READ: res_ok = 1'b1;
          OP_ACQUIRE: begin
            if (cur_g != '0) begin
              res_cnt = cur_g - 1'b1;
              res_ok  = 1'b1;
`ifdef SEM_OWNER_CHECK_EN
              owner_d[sem_ix] = gnt_idx;
`endif
            end
          end
          OP_RELEASE: begin
`ifdef SEM_OWNER_CHECK_EN
            if (owner_q[sem_ix] == gnt_idx && cur_g != CNT_MAX) begin
              res_cnt = cur_g + 1'b1;
              res_ok  = 1'b1;
              if (cur_g + 1'b1 == CNT_RST) owner_d[sem_ix] = '0;
            end
`else
            if (cur_g != CNT_MAX) begin
              res_cnt = cur_g + 1'b1;
              res_ok  = 1'b1;
            end
`endif
          end
          OP_INIT: begin
            res_cnt = data_g;
            res_ok  = 1'b1;
`ifdef SEM_OWNER_CHECK_EN
            owner_d[sem_ix] = gnt_idx;
`endif
          end
          default: res_ok = 1'b0;
        endcase
        cnt_d[sem_ix] = res_cnt;
      end
      ok_d[gnt_idx] = res_ok;
      rdata_d[CNT_W*int'(gnt_idx) +: CNT_W] = res_cnt;
    end
  end

  // Non-zero flags follow the post-op counts so they move with the ACK
  always_comb begin
    nz_d = '0;
    for (int i = 0; i < NUM_SEM; i++) nz_d[i] = (cnt_d[i] != '0);
  end

  // State and response registers
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      for (int i = 0; i < NUM_SEM; i++) begin
        cnt_q[i] <= CNT_RST;
`ifdef SEM_OWNER_CHECK_EN
        owner_q[i] <= '0;
`endif
      end
      rr_q    <= '0;
      ack_q   <= '0;
      ok_q    <= '0;
      rdata_q <= '0;
      nz_q    <= {NUM_SEM{RESET_CNT != 0}};
    end else begin
      for (int i = 0; i < NUM_SEM; i++) begin
        cnt_q[i] <= cnt_d[i];
`ifdef SEM_OWNER_CHECK_EN
        owner_q[i] <= owner_d[i];
`endif
      end
      rr_q    <= rr_d;
      ack_q   <= ack_d;
      ok_q    <= ok_d;
      rdata_q <= rdata_d;
      nz_q    <= nz_d;
    end
  end

  assign CORE_ACK    = ack_q;
  assign CORE_OK     = ok_q;
  assign CORE_RDATA  = rdata_q;
  assign SEM_NONZERO = nz_q;

endmodule
